// File: rtl/hwpe_ctrl_seq_div.sv
// rtl/hwpe_ctrl_seq_div.sv - sequential unsigned restoring divider, one quotient bit per cycle
// Optional feature macro: HWPE_CTRL_SEQ_DIV_EARLY_EXIT_EN (dividend < divisor finishes in one cycle)
module hwpe_ctrl_seq_div #(
    parameter int unsigned NW = 16,
    parameter int unsigned DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          start_i,
    input  logic [NW-1:0] dividend_i,
    input  logic [DW-1:0] divisor_i,
    output logic          busy_o,
    output logic          valid_o,
    output logic [NW-1:0] quot_o,
    output logic [DW-1:0] rem_o,
    output logic          div_by_zero_o
);

    localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [NW-1:0] quot_q, quot_d;
    logic [DW-1:0] dsr_q, dsr_d;
    logic          dbz_q, dbz_d;

    // The partial remainder is kept DW wide: its top bit is always 0 after a restoring step.
    logic [DW:0]   rem_shift;
    logic [DW-1:0] rem_sub;
    logic          rem_ge;

    assign rem_shift = {rem_q, quot_q[NW-1]};
    assign rem_ge    = (rem_shift >= {1'b0, dsr_q});
    assign rem_sub   = rem_shift[DW-1:0] - dsr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        dsr_d   = dsr_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (divisor_i == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = dividend_i[DW-1:0];
                        dbz_d   = 1'b1;
                    end
`ifdef HWPE_CTRL_SEQ_DIV_EARLY_EXIT_EN
                    else if (dividend_i < NW'(divisor_i)) begin
                        state_d = DONE;
                        quot_d  = '0;
                        rem_d   = dividend_i[DW-1:0];
                        dbz_d   = 1'b0;
                    end
`endif
                    else begin
                        state_d = RUN;
                        dsr_d   = divisor_i;
                        quot_d  = dividend_i;
                        rem_d   = '0;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                    end
                end
            end
            RUN: begin
                if (rem_ge) begin
                    rem_d  = rem_sub;
                    quot_d = {quot_q[NW-2:0], 1'b1};
                end else begin
                    rem_d  = rem_shift[DW-1:0];
                    quot_d = {quot_q[NW-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NW - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            dsr_q   <= '0;
            dbz_q   <= 1'b0;
        end else if (clear_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            dsr_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            dsr_q   <= dsr_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy_o        = (state_q != IDLE);
    assign valid_o       = (state_q == DONE);
    assign quot_o        = quot_q;
    assign rem_o         = rem_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_hwpe_ctrl_seq_div.sv
// tb/tb_hwpe_ctrl_seq_div.sv - randomized self-checking bench for hwpe_ctrl_seq_div
module tb_hwpe_ctrl_seq_div;

    localparam int unsigned NW = 16;
    localparam int unsigned DW = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic          start_i = 1'b0;
    logic [NW-1:0] dividend_i = '0;
    logic [DW-1:0] divisor_i = '0;
    logic          busy_o;
    logic          valid_o;
    logic [NW-1:0] quot_o;
    logic [DW-1:0] rem_o;
    logic          div_by_zero_o;

    int vectors = 0;
    int miscompares = 0;

    hwpe_ctrl_seq_div #(.NW(NW), .DW(DW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .start_i      (start_i),
        .dividend_i   (dividend_i),
        .divisor_i    (divisor_i),
        .busy_o       (busy_o),
        .valid_o      (valid_o),
        .quot_o       (quot_o),
        .rem_o        (rem_o),
        .div_by_zero_o(div_by_zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: plain integer arithmetic plus the documented latency rules.
    task automatic ref_div(input int unsigned a, input int unsigned b,
                           output int unsigned q, output int unsigned r,
                           output int unsigned dbz, output int unsigned lat);
        if (b == 0) begin
            q = 32'hFFFF; r = a % 256; dbz = 1; lat = 1;
        end else begin
            q = a / b; r = a % b; dbz = 0;
`ifdef HWPE_CTRL_SEQ_DIV_EARLY_EXIT_EN
            lat = (a < b) ? 1 : NW + 1;
`else
            lat = NW + 1;
`endif
        end
    endtask

    task automatic run_op(input string tag, input logic [NW-1:0] a, input logic [DW-1:0] b,
                          input int busy_start_at, input bit start_in_valid);
        int unsigned eq, er, edbz, elat;
        int lat, busy_cycles, valid_cycles;
        ref_div(a, b, eq, er, edbz, elat);
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
        dividend_i = NW'($urandom);
        divisor_i  = DW'($urandom);
        lat = 1;
        busy_cycles = 0;
        while (!valid_o && lat < 100) begin
            if (busy_o) busy_cycles++;
            if (lat == busy_start_at) begin
                dividend_i = 16'd9;
                divisor_i  = 8'd3;
                start_i    = 1'b1;
            end
            tick();
            start_i = 1'b0;
            lat++;
        end
        if (busy_o) busy_cycles++;
        check_val({tag, "_latency"}, lat, elat);
        check_val({tag, "_quot"}, quot_o, eq);
        check_val({tag, "_rem"}, rem_o, er);
        check_val({tag, "_dbz"}, div_by_zero_o, edbz);
        check_val({tag, "_busy_cycles"}, busy_cycles, elat);
        if (start_in_valid) begin
            dividend_i = 16'd100;
            divisor_i  = 8'd9;
            start_i    = 1'b1;
        end
        tick();
        start_i = 1'b0;
        valid_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid_o) valid_cycles++;
            if (i == 0) check_val({tag, "_busy_after"}, busy_o, 0);
            if (i == 19) begin
                check_val({tag, "_quot_held"}, quot_o, eq);
                check_val({tag, "_rem_held"}, rem_o, er);
            end
            if (i < 19) tick();
        end
        check_val({tag, "_extra_valid"}, valid_cycles, 0);
    endtask

    task automatic start_and_wait(input int n);
        dividend_i = 16'd1000;
        divisor_i  = 8'd7;
        start_i    = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 1; i < n; i++) tick();
    endtask

    initial begin
        int valid_seen;
        #2;
        check_val("reset_busy", busy_o, 0);
        check_val("reset_valid", valid_o, 0);
        check_val("reset_quot", quot_o, 0);
        check_val("reset_rem", rem_o, 0);
        check_val("reset_dbz", div_by_zero_o, 0);
        #20 rst_ni = 1'b1;
        tick();

        run_op("d1000_7", 16'd1000, 8'd7, 0, 1'b0);
        run_op("ffff_1", 16'hFFFF, 8'd1, 0, 1'b0);
        run_op("ffff_ff", 16'hFFFF, 8'hFF, 0, 1'b0);
        run_op("zero_5", 16'd0, 8'd5, 0, 1'b0);
        run_op("dbz_1234", 16'd1234, 8'd0, 0, 1'b0);
        run_op("d10_3", 16'd10, 8'd3, 0, 1'b0);
        run_op("busy_start", 16'd1000, 8'd7, 5, 1'b1);
        run_op("early_5_9", 16'd5, 8'd9, 0, 1'b0);

        // Clear mid-run aborts the operation without a valid pulse.
        start_and_wait(8);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check_val("clear_busy", busy_o, 0);
        check_val("clear_quot", quot_o, 0);
        check_val("clear_rem", rem_o, 0);
        valid_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid_o) valid_seen++;
            tick();
        end
        check_val("clear_no_valid", valid_seen, 0);

        // Asynchronous reset mid-run takes effect without a clock edge.
        start_and_wait(8);
        #2 rst_ni = 1'b0;
        #1;
        check_val("rst_busy", busy_o, 0);
        check_val("rst_quot", quot_o, 0);
        check_val("rst_rem", rem_o, 0);
        check_val("rst_dbz", div_by_zero_o, 0);
        tick();
        #2 rst_ni = 1'b1;
        tick();
        valid_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid_o) valid_seen++;
            tick();
        end
        check_val("rst_no_valid", valid_seen, 0);

        for (int n = 0; n < 40; n++) begin
            logic [NW-1:0] a;
            logic [DW-1:0] b;
            a = NW'($urandom);
            b = DW'($urandom);
            if (n % 8 == 0) b = '0;
            if (n % 8 == 1) a = NW'($urandom_range(0, 300));
            run_op($sformatf("rand%0d", n), a, b, 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hwpe_ctrl_seq_div.md
Name: hwpe_ctrl_seq_div

Overview:
- Fully sequential unsigned restoring divider; the inverse companion of the sequential multiplier in hwpe-ctrl.
- Computes loop bounds and tile counts (e.g. total length / tile size) inside HWPE controllers without a combinational divider.
- Resolves one quotient bit per cycle.
- Operands are latched at start, so the inputs need not be held stable afterwards.

Parameters:
NW  16  dividend and quotient width, >= 2
DW  8   divisor and remainder width, >= 1 and <= NW

Ports:
clk_i          in   1   clock
rst_ni         in   1   asynchronous active-low reset
clear_i        in   1   synchronous soft clear; priority over everything else
start_i        in   1   start strobe; sampled only in IDLE
dividend_i     in   NW  dividend; sampled when start is accepted
divisor_i      in   DW  divisor; sampled when start is accepted
busy_o         out  1   high in every state other than IDLE
valid_o        out  1   one-cycle pulse: results are valid
quot_o         out  NW  quotient, registered
rem_o          out  DW  remainder, registered
div_by_zero_o  out  1   sticky flag for the last operation: divisor was 0

Behaviour:
- Reset (async, rst_ni low):
  - state=IDLE
  - cycle counter=0
  - partial remainder=0
  - quot_o=0, rem_o=0, valid_o=0, busy_o=0, div_by_zero_o=0
  - Reset mid-operation aborts it; no valid_o pulse follows.
- clear_i (synchronous, at the clock edge):
  - Same register values as reset.
  - Beats start_i in the same cycle.
  - Aborts any operation in flight.
- FSM states: IDLE, RUN, DONE.
  - IDLE:
    - start_i=1 and divisor_i==0: go to DONE. Load quot=all ones, rem=dividend_i[DW-1:0], div_by_zero=1.
    - start_i=1 and divisor_i!=0: go to RUN. Latch the divisor; quotient register=dividend_i; partial remainder (DW+1 bits)=0; counter=0; div_by_zero=0.
  - RUN, each cycle:
    - r' = {r[DW-1:0], q[NW-1]}
    - q = {q[NW-2:0], 0}
    - If r' >= divisor: r = r' - divisor and q[0]=1; else r = r'.
    - Counter increments. When counter==NW-1 on that edge, go to DONE.
  - DONE: lasts exactly one cycle. valid_o=1 and busy_o=1. Next state is IDLE.
- Outputs:
  - quot_o is the quotient register.
  - rem_o is partial remainder [DW-1:0]; bit DW is always 0 after a restoring step.
- Hold rule: results and div_by_zero_o are held after DONE until the next accepted start, clear or reset. During RUN, quot_o and rem_o show intermediate values; they are valid only while valid_o=1.
- Latency:
  - start_i sampled at edge 0 (normal case): valid_o is high during the cycle after edge NW+1, i.e. NW+1 cycles after start.
  - Divide-by-zero: valid_o high during the cycle after edge 1.
- start_i while busy_o=1 is ignored; no queueing.
- start_i asserted in the same cycle valid_o=1 (state DONE) is ignored; the next start is accepted in IDLE.
- Edge cases:
  - Quotient and remainder always satisfy dividend = q*divisor + r with r < divisor.
  - dividend=0: q=0, r=0, full latency.
  - divisor=1: q=dividend, r=0.
  - No overflow is possible: the quotient fits NW bits.

Optional Feature:
Macro: HWPE_CTRL_SEQ_DIV_EARLY_EXIT_EN
- Defined: in IDLE, on a start with divisor_i!=0 and dividend_i < divisor_i (compared zero-extended), go directly to DONE with quot=0, rem=dividend_i[DW-1:0], div_by_zero=0. valid_o arrives 1 cycle after start. All other operations are unchanged.
- Undefined: no comparator is built. Such operands run the full NW-cycle sequence and produce the same q/r values with normal latency.

Test Plan:
(All with NW=16, DW=8.)
1. Normal divide: start with 1000/7 -> valid_o single pulse 17 cycles after start; quot_o=142, rem_o=6, div_by_zero_o=0; busy_o high for those 17 cycles; results held afterwards.
2. Boundaries: 0xFFFF/1 -> q=0xFFFF, r=0. 0xFFFF/0xFF -> q=0x0101, r=0. 0/5 -> q=0, r=0. All at full latency.
3. Divide by zero: 1234/0 -> valid_o 1 cycle after start; q=0xFFFF, r=0xD2, div_by_zero_o=1. A following 10/3 -> q=3, r=1, div_by_zero_o=0.
4. Start while busy: start 1000/7, then pulse start with 9/3 at cycle 5 -> ignored; exactly one valid_o, result 142/6. A new start in the valid_o cycle is also ignored.
5. Abort: clear_i at cycle 8 of a run -> next cycle busy_o=0, q=r=0, no valid_o. Repeat with rst_ni low mid-run -> same result, applied immediately.
6. Early exit: 5/9 -> q=0, r=5. With HWPE_CTRL_SEQ_DIV_EARLY_EXIT_EN, valid_o 1 cycle after start; without it, 17 cycles after start.
